// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch with debounced start/pause and clear keys, driving four BCD
// digit decoders. The count rate comes from an internal one-cycle tick enable.
module bcd_stopwatch #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk_50,
  input  logic       clr,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_MAX    = CW'(DB_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  // Bit 0 is the start key, bit 1 the clear key.
  logic [1:0]         keys;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         db_level;
  logic [1:0]         db_prev;
  logic [1:0]         press;
  logic [1:0][CW-1:0] db_cnt;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [PW-1:0] presc;
  logic          start_press;
  logic          clear_press;
  logic          at_max;
  logic          do_tick;
  logic          do_clear;
  logic          at_top;

  assign keys        = {key_clear_n, key_start_n};
  assign start_press = press[0];
  assign clear_press = press[1];

  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      sync1    <= '1;
      sync2    <= '1;
      db_level <= '1;
      db_prev  <= '1;
      press    <= '0;
      db_cnt   <= '0;
    end else begin
      sync1   <= keys;
      sync2   <= sync1;
      db_prev <= db_level;
      press   <= db_prev & ~db_level;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == db_level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_MAX) begin
          db_level[k] <= sync2[k];
          db_cnt[k]   <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + CW'(1);
        end
      end
    end
  end

  // Start takes priority over clear when both land in PAUSE together.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_press) state_next = RUN;
      RUN:     if (start_press) state_next = PAUSE;
      PAUSE: begin
        if (start_press)      state_next = RUN;
        else if (clear_press) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
    end
  end

  assign at_max   = (presc == PRESC_MAX);
  assign do_tick  = (state == RUN) && at_max;
  assign do_clear = (state == PAUSE) && clear_press && !start_press;
  assign at_top   = (min_tens == 4'd5) && (min_ones == 4'd9) &&
                    (sec_tens == 4'd5) && (sec_ones == 4'd9);

  // The prescaler freezes in PAUSE so a resumed run keeps its partial second.
  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      presc    <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else begin
      tick <= do_tick;
      wrap <= do_tick && at_top;

      if (state == RUN) begin
        presc <= at_max ? '0 : presc + PW'(1);
      end else if (state == IDLE) begin
        presc <= '0;
      end

      if (do_tick) begin
        if (sec_ones >= 4'd9) begin
          sec_ones <= 4'd0;
          if (sec_tens >= 4'd5) begin
            sec_tens <= 4'd0;
            if (min_ones >= 4'd9) begin
              min_ones <= 4'd0;
              if (min_tens >= 4'd5) begin
                min_tens <= 4'd0;
              end else begin
                min_tens <= min_tens + 4'd1;
              end
            end else begin
              min_ones <= min_ones + 4'd1;
            end
          end else begin
            sec_tens <= sec_tens + 4'd1;
          end
        end else begin
          sec_ones <= sec_ones + 4'd1;
        end
      end else if (do_clear) begin
        sec_ones <= 4'd0;
        sec_tens <= 4'd0;
        min_ones <= 4'd0;
        min_tens <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: an elapsed-seconds model checked every cycle, plus
// directed key sequences with hand-computed digit/flag expectations.
module tb_bcd_stopwatch;

  localparam int TICK_DIV  = 4;
  localparam int DB_CYCLES = 3;
  localparam int IDLE_S  = 0;
  localparam int RUN_S   = 1;
  localparam int PAUSE_S = 2;

  logic       clk_50      = 1'b0;
  logic       clr         = 1'b1;
  logic       key_start_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       tick;
  logic       wrap;

  int errors    = 0;
  int checks    = 0;
  int dut_ticks = 0;

  // Model: elapsed seconds as a plain integer, prescaler phase, mode.
  int       m_secs  = 0;
  int       m_presc = 0;
  int       m_state = IDLE_S;
  bit       m_tick  = 1'b0;
  bit       m_wrap  = 1'b0;
  bit [1:0] m_sync1 = 2'b11;
  bit [1:0] m_sync2 = 2'b11;
  bit [1:0] m_level = 2'b11;
  bit [1:0] m_press = 2'b00;
  bit [1:0] m_pend  = 2'b00;
  int       m_run [2] = '{0, 0};

  bcd_stopwatch #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk_50      (clk_50),
    .clr         (clr),
    .key_start_n (key_start_n),
    .key_clear_n (key_clear_n),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .min_tens    (min_tens),
    .running     (running),
    .tick        (tick),
    .wrap        (wrap)
  );

  always #10 clk_50 = ~clk_50;

  function automatic logic [15:0] bcd_of(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  // A key press is a run of DB_CYCLES consecutive differing synced samples.
  always @(posedge clk_50 or negedge clr) begin : model
    bit [1:0] fell;
    bit       ps;
    bit       pc;
    if (!clr) begin
      m_secs = 0; m_presc = 0; m_state = IDLE_S; m_tick = 0; m_wrap = 0;
      m_sync1 = 2'b11; m_sync2 = 2'b11; m_level = 2'b11;
      m_press = 2'b00; m_pend = 2'b00; m_run[0] = 0; m_run[1] = 0;
    end else begin
      ps = m_press[0];
      pc = m_press[1];
      m_tick = 0;
      m_wrap = 0;
      if (m_state == RUN_S) begin
        if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          m_tick  = 1;
          m_wrap  = (m_secs == 3599);
          m_secs  = (m_secs + 1) % 3600;
        end else begin
          m_presc = m_presc + 1;
        end
      end else if (m_state == IDLE_S) begin
        m_presc = 0;
      end
      if (m_state == PAUSE_S && pc && !ps) m_secs = 0;
      case (m_state)
        IDLE_S:  if (ps) m_state = RUN_S;
        RUN_S:   if (ps) m_state = PAUSE_S;
        default: if (ps) m_state = RUN_S; else if (pc) m_state = IDLE_S;
      endcase
      fell = 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (m_sync2[k] != m_level[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == DB_CYCLES) begin
            m_level[k] = m_sync2[k];
            m_run[k]   = 0;
            fell[k]    = !m_level[k];
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = {key_clear_n, key_start_n};
      m_press = m_pend;
      m_pend  = fell;
    end
  end

  always @(negedge clk_50) begin : compare
    logic [18:0] act;
    logic [18:0] expv;
    act  = {min_tens, min_ones, sec_tens, sec_ones, running, tick, wrap};
    expv = {bcd_of(m_secs), (m_state == RUN_S), m_tick, m_wrap};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL model_cmp t=%0t actual=%h required=%h", $time, act, expv);
    end
    if (tick === 1'b1) dut_ticks++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  // which: 0 = start key, 1 = clear key
  task automatic applyStimulus(input bit which, input int low_cycles);
    if (which) key_clear_n = 1'b0; else key_start_n = 1'b0;
    stepCycles(low_cycles);
    if (which) key_clear_n = 1'b1; else key_start_n = 1'b1;
  endtask

  task automatic waitTick(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk_50);
      waited++;
    end while (tick !== 1'b1 && waited < budget);
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL tick_timeout actual=none required=tick within %0d", budget);
    end
  endtask

  task automatic waitSecs(input int target, input int budget);
    int n;
    n = 0;
    while (m_secs != target && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    if (m_secs != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL secs_timeout actual=%0d required=%0d", m_secs, target);
    end
  endtask

  function automatic logic [31:0] digits();
    return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    int t0;
    int w;
    #1 clr = 1'b0;
    stepCycles(3);
    checkOutput("reset_digits", digits(), 32'h0000);
    checkOutput("reset_flags", {29'h0, running, tick, wrap}, 32'h0);
    clr = 1'b1;
    t0 = dut_ticks;
    stepCycles(100);
    checkOutput("idle_no_tick", dut_ticks - t0, 0);
    checkOutput("idle_running", {31'h0, running}, 0);

    key_start_n = 1'b0;
    stepCycles(6);
    checkOutput("run_latency_6", {31'h0, running}, 0);
    stepCycles(1);
    checkOutput("run_latency_7", {31'h0, running}, 1);
    stepCycles(3);
    key_start_n = 1'b1;
    waitTick(10, w);
    checkOutput("first_tick_delay", w, 1);
    for (int i = 0; i < 3; i++) begin
      waitTick(10, w);
      checkOutput("tick_period", w, 4);
    end
    waitSecs(10, 100);
    checkOutput("ten_seconds", digits(), 32'h0010);

    waitSecs(3598, 16000);
    checkOutput("preload_5958", digits(), 32'h5958);
    waitTick(10, w);
    checkOutput("at_5959", digits(), 32'h5959);
    checkOutput("no_wrap_5959", {31'h0, wrap}, 0);
    waitTick(10, w);
    checkOutput("wrap_digits", digits(), 32'h0000);
    checkOutput("wrap_with_tick", {30'h0, wrap, tick}, 32'h3);
    stepCycles(1);
    checkOutput("wrap_one_cycle", {31'h0, wrap}, 0);

    stepCycles(2);
    applyStimulus(1'b0, 4);
    stepCycles(3);
    checkOutput("paused", {31'h0, running}, 0);
    t0 = dut_ticks;
    stepCycles(50);
    checkOutput("pause_no_tick", dut_ticks - t0, 0);
    checkOutput("pause_hold", digits(), 32'h0002);
    applyStimulus(1'b0, 4);
    stepCycles(3);
    checkOutput("resume_running", {31'h0, running}, 1);
    checkOutput("resume_tick_r7", {31'h0, tick}, 0);
    stepCycles(1);
    checkOutput("resume_tick_r8", {31'h0, tick}, 0);
    stepCycles(1);
    checkOutput("resume_tick_r9", {31'h0, tick}, 1);
    checkOutput("resume_digits", digits(), 32'h0003);

    stepCycles(10);
    applyStimulus(1'b1, 4);
    stepCycles(10);
    checkOutput("clear_in_run_state", {31'h0, running}, 1);
    checkOutput("clear_in_run_count", digits(), 32'h0009);
    applyStimulus(1'b0, 4);
    stepCycles(3);
    checkOutput("pause2_state", {31'h0, running}, 0);
    checkOutput("pause2_digits", digits(), 32'h0010);
    stepCycles(7);
    applyStimulus(1'b1, 2);
    stepCycles(10);
    checkOutput("clear_glitch", digits(), 32'h0010);
    applyStimulus(1'b1, 4);
    stepCycles(3);
    checkOutput("clear_in_pause", digits(), 32'h0000);
    checkOutput("clear_to_idle", {31'h0, running}, 0);
    stepCycles(10);
    applyStimulus(1'b0, 2);
    stepCycles(10);
    checkOutput("start_glitch", {31'h0, running}, 0);

    applyStimulus(1'b0, 4);
    stepCycles(3);
    checkOutput("rerun_state", {31'h0, running}, 1);
    stepCycles(3);
    checkOutput("idle_presc_zero_e10", {31'h0, tick}, 0);
    stepCycles(1);
    checkOutput("idle_presc_zero_e11", {31'h0, tick}, 1);
    checkOutput("rerun_first_sec", digits(), 32'h0001);
    waitSecs(754, 4000);
    checkOutput("at_1234", digits(), 32'h1234);
    #3 clr = 1'b0;
    #1;
    checkOutput("async_reset_digits", digits(), 32'h0000);
    checkOutput("async_reset_flags", {29'h0, running, tick, wrap}, 32'h0);
    stepCycles(3);
    clr = 1'b1;
    t0 = dut_ticks;
    stepCycles(30);
    checkOutput("post_reset_idle", {31'h0, running}, 0);
    checkOutput("post_reset_no_tick", dut_ticks - t0, 0);
    applyStimulus(1'b0, 4);
    stepCycles(3);
    checkOutput("post_reset_start", {31'h0, running}, 1);
    stepCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
